// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall/flush controller.
//
// Derives per-stage hold, bubble and clear controls from per-stage stall
// requests and a single-cycle flush request. After reset the pipeline is held
// for RST_HOLD ready cycles. An accepted flush clears stages
// 0..FLUSH_STAGES-1 for FLUSH_HOLD effective cycles. A flush cycle is only
// effective when no surviving stage is stalled.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When it is defined, saturating stall-cycle and flush-event counters are
//   built. When it is undefined, both counter outputs are tied to zero.
//
// Ports:
//   clk          clock (single domain)
//   rst          synchronous active-high reset
//   rdy          global ready; low freezes the pipeline and this controller
//   stall_req    [STAGES] per-stage stall requests (bit 0 = IF)
//   flush_req    single-cycle flush request
//   stall_state  [STAGES] hold stage i
//   bubble       [STAGES] load a bubble into stage i
//   flush        [STAGES] clear stage i
//   busy         registered, high whenever the controller is not in RUN
//   stall_cycles [CNT_W] stall cycle counter
//   flush_events [CNT_W] accepted flush counter
module pipe_ctrl #(
  parameter int STAGES       = 5,
  parameter int FLUSH_STAGES = 2,
  parameter int FLUSH_HOLD   = 1,
  parameter int RST_HOLD     = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  output logic [STAGES-1:0] stall_state,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int HOLD_MAX = (FLUSH_HOLD > RST_HOLD) ? FLUSH_HOLD : RST_HOLD;
  localparam int CW       = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Mask with ones in bit positions below n.
  function automatic logic [STAGES-1:0] low_mask(input int n);
    logic [STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i < n) m[i] = 1'b1;
      else       m[i] = 1'b0;
    end
    return m;
  endfunction

  // Bit j is set when any request exists at index >= j. The result is the
  // hold pattern for "stall everything up to the highest requester".
  function automatic logic [STAGES-1:0] stall_prefix(input logic [STAGES-1:0] req);
    logic [STAGES-1:0] p;
    logic acc;
    acc = 1'b0;
    p   = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc  = acc | req[j];
      p[j] = acc;
    end
    return p;
  endfunction

  localparam logic [STAGES-1:0] FLUSH_MASK = low_mask(FLUSH_STAGES);
  localparam logic [CW-1:0]     RST_LOAD   = CW'(RST_HOLD);
  localparam logic [CW-1:0]     FLUSH_LOAD = CW'(FLUSH_HOLD);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic              busy_r;
  logic [STAGES-1:0] eff_req_s;
  logic [STAGES-1:0] pfx_s;

  // Next-state, down-counter and stage control decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_state = '1;
    bubble      = '0;
    flush       = '0;
    // Stages that are being cleared cannot usefully stall.
    if (state_r == ST_FLUSH) eff_req_s = stall_req & ~FLUSH_MASK;
    else                     eff_req_s = stall_req;
    pfx_s = stall_prefix(eff_req_s);

    if (!rdy) begin
      // Frozen: hold everything, no bubbles or clears, state untouched.
      stall_state = '1;
    end else begin
      case (state_r)
        ST_HOLD: begin
          stall_state = '1;
          cnt_nxt_s   = cnt_r - CNT_ONE;
          if (cnt_r <= CNT_ONE) state_nxt_s = ST_RUN;
          else                  state_nxt_s = ST_HOLD;
        end
        ST_RUN: begin
          stall_state = pfx_s;
          bubble      = {pfx_s[STAGES-2:0], 1'b0} & ~pfx_s;
          if (flush_req) begin
            state_nxt_s = ST_FLUSH;
            cnt_nxt_s   = FLUSH_LOAD;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          stall_state = pfx_s;
          bubble      = {pfx_s[STAGES-2:0], 1'b0} & ~pfx_s;
          flush       = FLUSH_MASK;
          if (flush_req) begin
            // Retrigger restarts the full flush window.
            cnt_nxt_s = FLUSH_LOAD;
          end else if (|eff_req_s) begin
            // Downstream held: this cycle does not count toward the flush.
            cnt_nxt_s = cnt_r;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            if (cnt_r <= CNT_ONE) state_nxt_s = ST_RUN;
            else                  state_nxt_s = ST_FLUSH;
          end
        end
        default: begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = RST_LOAD;
          stall_state = '1;
        end
      endcase
    end
  end

  // State, down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_HOLD;
      cnt_r   <= RST_LOAD;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != ST_RUN);
    end
  end

  assign busy = busy_r;

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_events_r;
  logic             stall_cnt_en_s;
  logic             flush_acc_s;

  assign stall_cnt_en_s = rdy & (state_r != ST_HOLD) & (|stall_state);
  assign flush_acc_s    = rdy & flush_req & ((state_r == ST_RUN) | (state_r == ST_FLUSH));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= '0;
      flush_events_r <= '0;
    end else begin
      if (stall_cnt_en_s) stall_cycles_r <= sat_inc(stall_cycles_r);
      else                stall_cycles_r <= stall_cycles_r;
      if (flush_acc_s)    flush_events_r <= sat_inc(flush_events_r);
      else                flush_events_r <= flush_events_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_events = flush_events_r;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. It runs directed vectors taken from a
// table, a counter saturation sequence and randomized traffic. All of these
// are compared against a behavioural model that tracks the remaining hold and
// flush cycles.
module tb_pipe_ctrl;

  localparam int STAGES = 5;
  localparam int FS     = 2;
  localparam int FH     = 2;
  localparam int RH     = 2;
  localparam int CW     = 4;
  localparam int CMAX   = 15;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic [STAGES-1:0] stall_req;
  logic              flush_req;
  logic [STAGES-1:0] stall_state;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] flush;
  logic              busy;
  logic [CW-1:0]     stall_cycles;
  logic [CW-1:0]     flush_events;

  pipe_ctrl #(
    .STAGES(STAGES), .FLUSH_STAGES(FS), .FLUSH_HOLD(FH), .RST_HOLD(RH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
    .stall_state(stall_state), .bubble(bubble), .flush(flush), .busy(busy),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int hold_left   = 0;
  int flush_left  = 0;
  int m_sc        = 0;
  int m_fe        = 0;
  bit model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_outs(input logic [4:0] req, input logic rd,
                                     output logic [4:0] st, output logic [4:0] bb,
                                     output logic [4:0] fl);
    logic [4:0] eff;
    int k;
    st = 5'b00000; bb = 5'b00000; fl = 5'b00000;
    if (!rd || hold_left > 0) begin
      st = 5'b11111;
    end else begin
      eff = req;
      if (flush_left > 0) begin
        for (int i = 0; i < FS; i++) begin
          eff[i] = 1'b0;
          fl[i]  = 1'b1;
        end
      end
      k = -1;
      for (int i = 0; i < STAGES; i++) if (eff[i]) k = i;
      if (k >= 0) begin
        st = 5'((1 << (k + 1)) - 1);
        if (k + 1 < STAGES) bb = 5'(1 << (k + 1));
      end
    end
  endfunction

  task automatic model_step(input logic [4:0] req, input logic fr, input logic rd, input logic rs);
    logic [4:0] st, bb, fl;
    if (rs) begin
      hold_left = RH; flush_left = 0; m_sc = 0; m_fe = 0; model_valid = 1'b1;
    end else if (rd && model_valid) begin
      model_outs(req, rd, st, bb, fl);
      if (hold_left == 0 && st != 5'b00000 && m_sc < CMAX) m_sc++;
      if (hold_left > 0) hold_left--;
      else if (fr) begin
        flush_left = FH;
        if (m_fe < CMAX) m_fe++;
      end else if (flush_left > 0 && st == 5'b00000) flush_left--;
    end
  endtask

  task automatic model_check(input logic [4:0] req, input logic rd);
    logic [4:0] st, bb, fl;
    int esc, efe;
    if (model_valid) begin
      model_outs(req, rd, st, bb, fl);
`ifdef PIPE_CTRL_PERF_EN
      esc = m_sc; efe = m_fe;
`else
      esc = 0; efe = 0;
`endif
      chk("m_stall_state",  32'(stall_state),  32'(st));
      chk("m_bubble",       32'(bubble),       32'(bb));
      chk("m_flush",        32'(flush),        32'(fl));
      chk("m_busy",         32'(busy),         32'(hold_left > 0 || flush_left > 0));
      chk("m_stall_cycles", 32'(stall_cycles), 32'(esc));
      chk("m_flush_events", 32'(flush_events), 32'(efe));
    end
  endtask

  // Apply inputs, check mid-cycle, then advance one clock.
  task automatic cycle(input logic [4:0] req, input logic fr, input logic rd, input logic rs);
    stall_req = req; flush_req = fr; rdy = rd; rst = rs;
    #2;
    model_check(req, rd);
    @(posedge clk);
    model_step(req, fr, rd, rs);
    #1;
  endtask

  typedef struct {
    logic       rs;
    logic       rd;
    logic       fr;
    logic [4:0] req;
    logic       chk_en;
    logic [4:0] e_st;
    logic [4:0] e_bb;
    logic [4:0] e_fl;
    logic       e_busy;
  } vec_t;

  vec_t tbl[28];

  initial begin
    //          rs    rd    fr    req       chk   e_st      e_bb      e_fl      busy
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'b00110, 1'b1, 5'b00111, 5'b01000, 5'b00000, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'b10000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 5'b01000, 1'b1, 5'b01111, 5'b10000, 5'b00011, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5'b01000, 1'b1, 5'b01111, 5'b10000, 5'b00011, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 5'b00001, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 1'b1, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b1};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00011, 1'b1};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 1'b0, 5'b00100, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b0};

    stall_req = 5'b00000; flush_req = 1'b0; rdy = 1'b1; rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 28; i++) begin
      stall_req = tbl[i].req; flush_req = tbl[i].fr; rdy = tbl[i].rd; rst = tbl[i].rs;
      #2;
      if (tbl[i].chk_en) begin
        chk($sformatf("t%0d_stall_state", i), 32'(stall_state), 32'(tbl[i].e_st));
        chk($sformatf("t%0d_bubble", i),      32'(bubble),      32'(tbl[i].e_bb));
        chk($sformatf("t%0d_flush", i),       32'(flush),       32'(tbl[i].e_fl));
        chk($sformatf("t%0d_busy", i),        32'(busy),        32'(tbl[i].e_busy));
      end
      model_check(tbl[i].req, tbl[i].rd);
      @(posedge clk);
      model_step(tbl[i].req, tbl[i].fr, tbl[i].rd, tbl[i].rs);
      #1;
    end

    // Counter saturation: fresh reset, hold window, then 20 stalled cycles
    cycle(5'b00000, 1'b0, 1'b1, 1'b1);
    cycle(5'b00000, 1'b0, 1'b1, 1'b0);
    cycle(5'b00000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(5'b00001, 1'b0, 1'b1, 1'b0);
    stall_req = 5'b00000;
    #2;
`ifdef PIPE_CTRL_PERF_EN
    chk("sat_stall_cycles", 32'(stall_cycles), 32'd15);
`else
    chk("sat_stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    chk("sat_flush_events", 32'(flush_events), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r_req;
      logic       r_fr, r_rd, r_rs;
      r_req = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      r_fr  = ($urandom_range(0, 5) == 0);
      r_rd  = ($urandom_range(0, 7) != 0);
      r_rs  = ($urandom_range(0, 99) == 0);
      cycle(r_req, r_fr, r_rd, r_rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
